// File: rtl/mul_pkg.sv
// Shared types for the progressive-add multiplier.
// Holds the controller state encoding and the default operand width.
package mul_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mul_pa_datapath.sv
// Datapath for the progressive-add multiplier.
// Ports: clk, rst (async high), data_in (operand bus),
//   ld_a, ld_b, ld_p, clr_p, dec_b (controls), product, eqz.
module mul_pa_datapath #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             ld_p,
    input  logic             clr_p,
    input  logic             dec_b,
    output logic [WIDTH-1:0] product,
    output logic             eqz
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] p_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            if (ld_a)
                a_q <= data_in;

            if (ld_b)
                b_q <= data_in;
            else if (dec_b)
                b_q <= b_q - ONE;

            // Clear wins so a new product never inherits a partial sum.
            if (clr_p)
                p_q <= '0;
            else if (ld_p)
                p_q <= p_q + a_q;
        end
    end

    assign eqz     = (b_q == '0);
    assign product = p_q;

endmodule

// File: rtl/mul_progressive_add.sv
// Unsigned multiplier: adds A into P, B times, using one operand bus.
// Ports: clk, rst (async high), start, data_in, product, done, eqz.
module mul_progressive_add
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] product,
    output logic             done,
    output logic             eqz
);

    state_t state;

    logic ld_a;
    logic ld_b;
    logic ld_p;
    logic clr_p;
    logic dec_b;

    // Controls come from the state register; ADD also looks at the
    // B counter to stop adding once it has reached zero.
    assign ld_a  = (state == LOAD_A);
    assign ld_b  = (state == LOAD_B);
    assign clr_p = (state == LOAD_B);
    assign ld_p  = (state == ADD) && !eqz;
    assign dec_b = (state == ADD) && !eqz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start)
                        state <= LOAD_A;
                end
                LOAD_A: begin
                    state <= LOAD_B;
                end
                LOAD_B: begin
                    state <= ADD;
                end
                ADD: begin
                    if (eqz) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    // Held start keeps us here so it cannot retrigger.
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    mul_pa_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .ld_a    (ld_a),
        .ld_b    (ld_b),
        .ld_p    (ld_p),
        .clr_p   (clr_p),
        .dec_b   (dec_b),
        .product (product),
        .eqz     (eqz)
    );

endmodule

// File: tb/tb_mul_progressive_add.sv
// Self-checking bench for mul_progressive_add.
// Reference: product = (A*B) mod 2^16, done first seen after edge 3+B.
module tb_mul_progressive_add;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic [15:0] product;
    logic        done;
    logic        eqz;

    int tests;
    int fails;

    mul_progressive_add #(
        .WIDTH(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .product (product),
        .done    (done),
        .eqz     (eqz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_prod(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [31:0] full;
        full = 32'(a) * 32'(b);
        return full[15:0];
    endfunction

    // Drives one multiplication and returns the edge number (edge 0
    // samples start) after which done was first seen high.
    // -2: done high too early; -1: done never rose within the bound.
    task automatic run_mul(
        input  logic [15:0] a,
        input  logic [15:0] b,
        input  bit          hold,
        output int          n
    );
        bit early;
        early = 1'b0;
        n = -1;
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'($urandom);
        @(posedge clk); #1;
        if (done) early = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        data_in = a;
        @(posedge clk); #1;
        if (done) early = 1'b1;
        @(negedge clk);
        data_in = b;
        @(posedge clk); #1;
        if (done) early = 1'b1;
        for (int e = 3; e <= 400; e++) begin
            @(negedge clk);
            data_in = 16'($urandom);
            @(posedge clk); #1;
            if (done) begin
                n = e;
                break;
            end
        end
        if (early) n = -2;
    endtask

    task automatic leave_done();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        tests++;
        if (product !== 16'd0 || done !== 1'b0 || eqz !== 1'b1) begin
            fails++;
            $display("FAIL reset: p=%0d done=%b eqz=%b want 0/0/1",
                     product, done, eqz);
        end
    endtask

    task automatic test_held_start();
        int n;
        run_mul(16'd100, 16'd17, 1'b1, n);
        tests++;
        if (n !== 20) begin
            fails++;
            $display("FAIL held_lat: edge=%0d want 20", n);
        end
        tests++;
        if (product !== 16'd1700 || eqz !== 1'b1) begin
            fails++;
            $display("FAIL held_val: p=%0d eqz=%b want 1700/1",
                     product, eqz);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b1 || product !== 16'd1700) begin
            fails++;
            $display("FAIL held_stay: done=%b p=%0d want 1/1700",
                     done, product);
        end
        leave_done();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL held_exit: done=%b want 0", done);
        end
    endtask

    task automatic test_b_zero();
        int n;
        run_mul(16'd25, 16'd0, 1'b0, n);
        tests++;
        if (n !== 3 || product !== 16'd0) begin
            fails++;
            $display("FAIL b_zero: edge=%0d p=%0d want 3/0", n, product);
        end
        leave_done();
    endtask

    task automatic test_a_zero();
        int n;
        run_mul(16'd0, 16'd5, 1'b0, n);
        tests++;
        if (n !== 8 || product !== 16'd0) begin
            fails++;
            $display("FAIL a_zero: edge=%0d p=%0d want 8/0", n, product);
        end
        leave_done();
    endtask

    task automatic test_wrap();
        int n;
        run_mul(16'h4000, 16'd5, 1'b0, n);
        tests++;
        if (n !== 8 || product !== 16'h4000) begin
            fails++;
            $display("FAIL wrap: edge=%0d p=%h want 8/4000", n, product);
        end
        leave_done();
    endtask

    task automatic test_back_to_back();
        int n;
        run_mul(16'd7, 16'd6, 1'b1, n);
        tests++;
        if (n !== 9 || product !== 16'd42) begin
            fails++;
            $display("FAIL b2b_first: edge=%0d p=%0d want 9/42",
                     n, product);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_hold: done=%b want 1", done);
        end
        leave_done();
        run_mul(16'd9, 16'd3, 1'b0, n);
        tests++;
        if (n !== 6 || product !== 16'd27) begin
            fails++;
            $display("FAIL b2b_second: edge=%0d p=%0d want 6/27",
                     n, product);
        end
        leave_done();
    endtask

    task automatic test_reset_mid_add();
        int n;
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd0;
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'd5;
        @(negedge clk);
        data_in = 16'd10;
        repeat (4) @(negedge clk);
        tests++;
        if (product !== 16'd15 || eqz !== 1'b0) begin
            fails++;
            $display("FAIL mid_pre: p=%0d eqz=%b want 15/0",
                     product, eqz);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (product !== 16'd0 || done !== 1'b0 || eqz !== 1'b1) begin
            fails++;
            $display("FAIL mid_rst: p=%0d done=%b eqz=%b want 0/0/1",
                     product, done, eqz);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0 || product !== 16'd0) begin
            fails++;
            $display("FAIL mid_idle: done=%b p=%0d want 0/0",
                     done, product);
        end
        run_mul(16'd3, 16'd4, 1'b0, n);
        tests++;
        if (n !== 7 || product !== 16'd12) begin
            fails++;
            $display("FAIL mid_after: edge=%0d p=%0d want 7/12",
                     n, product);
        end
        leave_done();
    endtask

    task automatic test_random();
        int          n;
        logic [15:0] a;
        logic [15:0] b;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom);
            b = 16'($urandom_range(0, 40));
            run_mul(a, b, bit'($urandom_range(0, 1)), n);
            tests++;
            if (n !== 3 + int'(b) || product !== ref_prod(a, b)) begin
                fails++;
                $display("FAIL rand%0d: a=%0d b=%0d edge=%0d p=%0d want %0d/%0d",
                         i, a, b, n, product, 3 + int'(b), ref_prod(a, b));
            end
            leave_done();
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = 16'd0;
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_held_start();
        test_b_zero();
        test_a_zero();
        test_wrap();
        test_back_to_back();
        test_reset_mid_add();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_progressive_add.md
Name: mul_progressive_add

Overview:
- Unsigned multiplier that forms A*B by adding A into an accumulator B times.
- Split into a datapath and a Moore controller that share six internal control/status signals: ldA, ldB, ldP, clrP, decB, eqz.
- Both operands enter serially on one shared input bus.
- Small, low-area arithmetic helper; not throughput-critical.

Parameters:
- WIDTH, 16, width of the operand bus, operand registers A and B, and the product register P.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request to begin a multiplication; sampled only in IDLE and DONE.
- data_in  input  WIDTH  shared operand bus: A in LOAD_A cycle, B in LOAD_B cycle.
- product  output  WIDTH  accumulator P; final result valid while done=1.
- done  output  1  high while the controller is in DONE.
- eqz  output  1  status flag, high when the B counter equals 0 (combinational from B).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; A=0, B=0, P=0.
  - done=0; eqz=1.
- Datapath:
  - A register loads data_in when ldA=1.
  - B is a down-counter: loads data_in when ldB=1; decrements when decB=1.
  - P loads 0 when clrP=1; loads P+A when ldP=1; clrP has priority over ldP.
  - eqz = (B == 0).
  - Adder is WIDTH bits; the sum wraps modulo 2^WIDTH and no overflow flag is produced.
- Controller (Moore; all control signals decoded from registered state only):
  - IDLE: all control signals 0. Go to LOAD_A if start=1, else stay.
  - LOAD_A: ldA=1. Next state LOAD_B.
  - LOAD_B: ldB=1, clrP=1. Next state ADD.
  - ADD, eqz=0: ldP=1, decB=1, stay in ADD.
  - ADD, eqz=1: no load, go to DONE.
  - DONE: done=1; P, A and B hold. Go to IDLE if start=0; stay in DONE while start=1, so a held start cannot retrigger.
- Latency (edge 0 = the edge that samples start=1 in IDLE):
  - A captured at edge 1; B captured and P cleared at edge 2.
  - Additions occur at edges 3 .. 2+B.
  - DONE is entered at edge 3+B; done rises after that edge.
- Boundary conditions:
  - B=0: zero additions, product=0, DONE entered at edge 3.
  - A=0: B cycles of adding 0, product=0.
  - data_in is ignored outside LOAD_A and LOAD_B.
  - rst asserted mid-operation returns to IDLE immediately and clears A, B, P; no partial result is retained.
  - An unreachable state encoding returns to IDLE on the next edge.

Decomposition:
- Shared package mul_pkg:
  - state enum IDLE, LOAD_A, LOAD_B, ADD, DONE (3-bit encoding).
  - default WIDTH constant.
- One natural sub-module: mul_pa_datapath, containing the A register, B counter, P register, adder and zero comparator.
- The controller FSM stays in the top level mul_progressive_add and drives the datapath control signals.

Test Plan:
- Reset mid-ADD (rst pulsed while B=10) -> product=0, done=0, eqz=1 immediately; state IDLE; a new start works normally.
- start=1 held; data_in=100 during LOAD_A, 17 during LOAD_B -> done rises 20 edges after the start-sampling edge; product=1700; eqz=1.
- A=25, B=0 -> product=0; done after 3 edges.
- A=0, B=5 -> product=0; done after 8 edges.
- A=0x4000, B=5 -> product=0x4000 (0x14000 wraps modulo 2^16); verifies wrap.
- Back-to-back: 7*6 then 9*3, start deasserted one cycle in DONE between them -> product=42 then 27; P cleared in LOAD_B, so there is no carry-over; done stays high while start is held in DONE.
